// File: rtl/othello_pkg.sv
// Shared Othello board definitions: cell codes, direction steps, board size
// and the flip sequencer state encoding.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_BLACK  = 2'b01;
  localparam logic [1:0] CELL_WHITE  = 2'b10;
  localparam logic [1:0] CELL_BORDER = 2'b11;

  localparam int STEP_U = -10;
  localparam int STEP_D = 10;
  localparam int STEP_L = -1;
  localparam int STEP_R = 1;

  localparam int BOARD_SIZE = 100;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_ORIGIN = 3'd1;
  localparam logic [2:0] ST_SEL_DIR   = 3'd2;
  localparam logic [2:0] ST_READ      = 3'd3;
  localparam logic [2:0] ST_CHECK     = 3'd4;
  localparam logic [2:0] ST_FLIP      = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  function automatic logic [1:0] opponent(input logic [1:0] p);
    return ~p;
  endfunction

endpackage

// File: rtl/flip_sequencer.sv
// Applies an already-validated Othello move: writes the placed disc, then walks
// each requested direction flipping opponent discs until a non-opponent cell.
module flip_sequencer
  import othello_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int MAX_RUN = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] origin_addr,
  input  logic [1:0]        player,
  input  logic [3:0]        dir_mask,
  input  logic [1:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [5:0]        flip_count
);

  localparam int CW    = ADDR_W + 1;
  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam logic signed [CW-1:0] LAST_CELL = CW'(BOARD_SIZE - 1);

  logic [2:0]              state;
  logic [ADDR_W-1:0]       origin_q;
  logic [1:0]              player_q;
  logic [3:0]              pend;
  logic signed [CW-1:0]    step_q;
  logic signed [CW-1:0]    cursor;
  logic [RUN_W-1:0]        run;

  logic signed [CW-1:0]    origin_ext;
  logic signed [CW-1:0]    sel_step;
  logic [3:0]              sel_clr;
  logic                    cursor_oob;

  assign origin_ext = $signed({1'b0, origin_q});

  // Off-board cursors behave like a border cell and are never put on the bus.
  assign cursor_oob = cursor[CW-1] || (cursor > LAST_CELL);

  always_comb begin
    sel_step = '0;
    sel_clr  = 4'b0000;
    if (pend[3]) begin
      sel_step = CW'(STEP_U);
      sel_clr  = 4'b1000;
    end else if (pend[2]) begin
      sel_step = CW'(STEP_D);
      sel_clr  = 4'b0100;
    end else if (pend[1]) begin
      sel_step = CW'(STEP_L);
      sel_clr  = 4'b0010;
    end else if (pend[0]) begin
      sel_step = CW'(STEP_R);
      sel_clr  = 4'b0001;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      origin_q   <= '0;
      player_q   <= '0;
      pend       <= '0;
      step_q     <= '0;
      cursor     <= '0;
      run        <= '0;
      flip_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            origin_q   <= origin_addr;
            player_q   <= player;
            pend       <= dir_mask;
            flip_count <= '0;
            state      <= ST_WR_ORIGIN;
          end
        end
        ST_WR_ORIGIN: state <= ST_SEL_DIR;
        ST_SEL_DIR: begin
          if (pend != 4'b0000) begin
            pend   <= pend & ~sel_clr;
            step_q <= sel_step;
            cursor <= origin_ext + sel_step;
            run    <= '0;
            state  <= ST_READ;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_READ: state <= ST_CHECK;
        ST_CHECK: begin
          if (!cursor_oob && (mem_rdata == opponent(player_q)) &&
              (run < RUN_W'(MAX_RUN)))
            state <= ST_FLIP;
          else
            state <= ST_SEL_DIR;
        end
        ST_FLIP: begin
          flip_count <= flip_count + 6'd1;
          run        <= run + RUN_W'(1);
          cursor     <= cursor + step_q;
          state      <= ST_READ;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    mem_we   = (state == ST_WR_ORIGIN) || (state == ST_FLIP);
    mem_addr = '0;
    case (state)
      ST_WR_ORIGIN: mem_addr = origin_q;
      ST_READ, ST_CHECK, ST_FLIP:
        mem_addr = cursor_oob ? '0 : cursor[ADDR_W-1:0];
      default: mem_addr = '0;
    endcase
  end

  assign mem_wdata = player_q;

endmodule

// File: tb/tb_flip_sequencer.sv
// Bench for flip_sequencer: board memory model, move reference model and
// directed plus randomized move scenarios.
module tb_flip_sequencer;

  localparam int ADDR_W  = 7;
  localparam int MAX_RUN = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] origin_addr;
  logic [1:0]        player;
  logic [3:0]        dir_mask;
  logic [1:0]        mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [1:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic [5:0]        flip_count;

  flip_sequencer #(.ADDR_W(ADDR_W), .MAX_RUN(MAX_RUN)) dut (
    .clock(clock), .reset(reset), .start(start), .origin_addr(origin_addr),
    .player(player), .dir_mask(dir_mask), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .flip_count(flip_count)
  );

  always #5 clock = ~clock;

  logic [1:0] board      [0:127];
  logic [1:0] init_board [0:127];
  logic [1:0] exp_board  [0:127];
  logic       load = 1'b0;

  int wr_q[$];
  int exp_wr[$];
  int done_total = 0;
  int bad_addr   = 0;
  int exp_flips;
  int exp_cyc;
  int checks = 0;
  int errors = 0;

  // Synchronous-read board memory.
  always @(posedge clock) begin
    if (load) board <= init_board;
    else if (mem_we) board[mem_addr] <= mem_wdata;
    mem_rdata <= board[mem_addr];
  end

  always @(negedge clock) begin
    if (reset && mem_we) wr_q.push_back(int'(mem_addr) * 4 + int'(mem_wdata));
    if (done) done_total <= done_total + 1;
    if (busy && (int'(mem_addr) > 99)) bad_addr <= bad_addr + 1;
  end

  task automatic clear_board();
    for (int i = 0; i < 128; i++)
      init_board[i] = (i >= 90 || i < 10 || (i % 10) == 0 || (i % 10) == 9) ? 2'b11 : 2'b00;
  endtask

  task automatic load_board();
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  // Move semantics straight from the rules: placed disc, then each requested
  // direction in U,D,L,R order flips consecutive opponent discs (capped).
  task automatic model(input int o, input logic [1:0] pl, input logic [3:0] m);
    int steps[4] = '{-10, 10, -1, 1};
    int nd, pos, run;
    exp_board = init_board;
    exp_wr.delete();
    exp_wr.push_back(o * 4 + int'(pl));
    exp_board[o] = pl;
    exp_flips = 0;
    nd = 0;
    for (int d = 0; d < 4; d++) begin
      if (m[3-d]) begin
        nd++;
        pos = o + steps[d];
        run = 0;
        while (pos >= 0 && pos <= 99 && exp_board[pos] == ~pl && run < MAX_RUN) begin
          exp_wr.push_back(pos * 4 + int'(pl));
          exp_board[pos] = pl;
          exp_flips++;
          run++;
          pos += steps[d];
        end
      end
    end
    exp_cyc = 3 + 3 * nd + 3 * exp_flips;
  endtask

  // Called at a falling edge; returns the cycle (after the start edge) of done.
  task automatic run_move(input int o, input logic [1:0] p, input logic [3:0] m,
                          output int cyc);
    start = 1'b1;
    origin_addr = ADDR_W'(o);
    player = p;
    dir_mask = m;
    cyc = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    origin_addr = '0;
    player = 2'b00;
    dir_mask = 4'b0000;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    checks++; if (flip_count !== 6'd0) begin errors++; $display("FAIL reset_flip_count: got %0d expected 0", flip_count); end
    checks++; if (mem_wdata !== 2'b00) begin errors++; $display("FAIL reset_wdata: got %b expected 00", mem_wdata); end
  endtask

  task automatic test_up_single();
    int cyc, wb, bb;
    clear_board();
    init_board[34] = 2'b10;
    init_board[24] = 2'b01;
    load_board();
    model(44, 2'b01, 4'b1000);
    wb = wr_q.size();
    bb = bad_addr;
    reset = 1'b1;
    run_move(44, 2'b01, 4'b1000, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL up_cycles: got %0d expected 9", cyc); end
    checks++; if (flip_count !== 6'd1) begin errors++; $display("FAIL up_flip_count: got %0d expected 1", flip_count); end
    checks++;
    if (wr_q.size() - wb !== exp_wr.size()) begin
      errors++; $display("FAIL up_nwrites: got %0d expected %0d", wr_q.size() - wb, exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (wr_q[wb+i] !== exp_wr[i]) begin
        errors++; $display("FAIL up_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                           i, wr_q[wb+i] / 4, wr_q[wb+i] % 4, exp_wr[i] / 4, exp_wr[i] % 4);
      end
    end
    checks++; if (board[34] !== 2'b01) begin errors++; $display("FAIL up_cell34: got %b expected 01", board[34]); end
  endtask

  task automatic test_left_right();
    int cyc, wb;
    clear_board();
    init_board[43] = 2'b01; init_board[42] = 2'b10;
    init_board[45] = 2'b01; init_board[46] = 2'b01; init_board[47] = 2'b10;
    load_board();
    model(44, 2'b10, 4'b0011);
    wb = wr_q.size();
    run_move(44, 2'b10, 4'b0011, cyc);
    checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL lr_cycles: got %0d expected %0d", cyc, exp_cyc); end
    checks++; if (flip_count !== 6'd3) begin errors++; $display("FAIL lr_flip_count: got %0d expected 3", flip_count); end
    checks++;
    if (wr_q.size() - wb !== 4) begin
      errors++; $display("FAIL lr_nwrites: got %0d expected 4", wr_q.size() - wb);
    end else foreach (exp_wr[i]) begin
      checks++;
      if (wr_q[wb+i] !== exp_wr[i]) begin
        errors++; $display("FAIL lr_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                           i, wr_q[wb+i] / 4, wr_q[wb+i] % 4, exp_wr[i] / 4, exp_wr[i] % 4);
      end
    end
  endtask

  task automatic test_empty_mask();
    int cyc, wb;
    clear_board();
    init_board[45] = 2'b10;
    load_board();
    wb = wr_q.size();
    run_move(44, 2'b01, 4'b0000, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL empty_cycles: got %0d expected 3", cyc); end
    checks++; if (flip_count !== 6'd0) begin errors++; $display("FAIL empty_flip_count: got %0d expected 0", flip_count); end
    checks++;
    if (wr_q.size() - wb !== 1) begin
      errors++; $display("FAIL empty_nwrites: got %0d expected 1", wr_q.size() - wb);
    end else begin
      checks++;
      if (wr_q[wb] !== 44 * 4 + 1) begin
        errors++; $display("FAIL empty_write: got addr %0d data %0d expected addr 44 data 1",
                           wr_q[wb] / 4, wr_q[wb] % 4);
      end
    end
  endtask

  task automatic test_border();
    int orgs[3] = '{11, 1, 95};
    logic [3:0] msks[3] = '{4'b1000, 4'b1000, 4'b0100};
    int cyc, wb, bb;
    for (int t = 0; t < 3; t++) begin
      clear_board();
      load_board();
      model(orgs[t], 2'b01, msks[t]);
      wb = wr_q.size();
      bb = bad_addr;
      run_move(orgs[t], 2'b01, msks[t], cyc);
      repeat (2) @(negedge clock);
      checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL border%0d_cycles: got %0d expected %0d", t, cyc, exp_cyc); end
      checks++; if (flip_count !== 6'd0) begin errors++; $display("FAIL border%0d_flip_count: got %0d expected 0", t, flip_count); end
      checks++; if (wr_q.size() - wb !== 1) begin errors++; $display("FAIL border%0d_nwrites: got %0d expected 1", t, wr_q.size() - wb); end
      checks++; if (bad_addr !== bb) begin errors++; $display("FAIL border%0d_addr_range: got %0d off-board addresses expected 0", t, bad_addr - bb); end
    end
  endtask

  task automatic test_random();
    int cyc, wb, bb, nbad, o, r;
    logic [1:0] p;
    logic [3:0] m;
    for (int n = 0; n < 40; n++) begin
      clear_board();
      p = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      for (int i = 0; i < 100; i++) begin
        if (init_board[i] != 2'b11) begin
          r = $urandom_range(0, 3);
          init_board[i] = (r == 0) ? 2'b00 : (r == 1) ? p : ~p;
        end
      end
      o = (1 + $urandom_range(0, 7)) * 10 + 1 + $urandom_range(0, 7);
      m = 4'($urandom_range(0, 15));
      load_board();
      model(o, p, m);
      wb = wr_q.size();
      bb = bad_addr;
      run_move(o, p, m, cyc);
      repeat (2) @(negedge clock);
      checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL rand%0d_cycles: got %0d expected %0d", n, cyc, exp_cyc); end
      checks++; if (flip_count !== 6'(exp_flips)) begin errors++; $display("FAIL rand%0d_flip_count: got %0d expected %0d", n, flip_count, exp_flips); end
      checks++;
      if (wr_q.size() - wb !== exp_wr.size()) begin
        errors++; $display("FAIL rand%0d_nwrites: got %0d expected %0d", n, wr_q.size() - wb, exp_wr.size());
      end else foreach (exp_wr[i]) begin
        checks++;
        if (wr_q[wb+i] !== exp_wr[i]) begin
          errors++; $display("FAIL rand%0d_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                             n, i, wr_q[wb+i] / 4, wr_q[wb+i] % 4, exp_wr[i] / 4, exp_wr[i] % 4);
        end
      end
      nbad = 0;
      for (int i = 0; i < 100; i++) if (board[i] !== exp_board[i]) nbad++;
      checks++; if (nbad !== 0) begin errors++; $display("FAIL rand%0d_board: got %0d wrong cells expected 0", n, nbad); end
      checks++; if (bad_addr !== bb) begin errors++; $display("FAIL rand%0d_addr_range: got %0d off-board addresses expected 0", n, bad_addr - bb); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, wb, db;
    bit injected;
    clear_board();
    init_board[43] = 2'b01; init_board[42] = 2'b10;
    init_board[45] = 2'b01; init_board[46] = 2'b01; init_board[47] = 2'b10;
    load_board();
    model(44, 2'b10, 4'b0011);
    wb = wr_q.size();
    db = done_total;
    injected = 1'b0;
    cyc = 0;
    start = 1'b1; origin_addr = 7'd44; player = 2'b10; dir_mask = 4'b0011;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (!injected && mem_we === 1'b1 && mem_addr !== 7'd44) begin
        start = 1'b1; origin_addr = 7'd55; player = 2'b01; dir_mask = 4'b1111;
        injected = 1'b1;
      end
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
    start = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (injected !== 1'b1) begin errors++; $display("FAIL b2b_injected: got %b expected 1", injected); end
    checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL b2b_cycles: got %0d expected %0d", cyc, exp_cyc); end
    checks++; if (done_total - db !== 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 1", done_total - db); end
    checks++; if (flip_count !== 6'd3) begin errors++; $display("FAIL b2b_flip_count_hold: got %0d expected 3", flip_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b expected 0", busy); end
    checks++;
    if (wr_q.size() - wb !== exp_wr.size()) begin
      errors++; $display("FAIL b2b_nwrites: got %0d expected %0d", wr_q.size() - wb, exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (wr_q[wb+i] !== exp_wr[i]) begin
        errors++; $display("FAIL b2b_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                           i, wr_q[wb+i] / 4, wr_q[wb+i] % 4, exp_wr[i] / 4, exp_wr[i] % 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, wb;
    clear_board();
    init_board[34] = 2'b10; init_board[24] = 2'b10; init_board[14] = 2'b01;
    load_board();
    start = 1'b1; origin_addr = 7'd44; player = 2'b01; dir_mask = 4'b1000;
    repeat (4) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL midrst_addr: got %0d expected 0", mem_addr); end
    checks++; if (flip_count !== 6'd0) begin errors++; $display("FAIL midrst_flip_count: got %0d expected 0", flip_count); end
    checks++; if (mem_wdata !== 2'b00) begin errors++; $display("FAIL midrst_wdata: got %b expected 00", mem_wdata); end
    @(negedge clock);
    reset = 1'b1;
    clear_board();
    init_board[34] = 2'b10; init_board[24] = 2'b10; init_board[14] = 2'b01;
    load_board();
    model(44, 2'b01, 4'b1000);
    wb = wr_q.size();
    run_move(44, 2'b01, 4'b1000, cyc);
    checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL midrst_rerun_cycles: got %0d expected %0d", cyc, exp_cyc); end
    checks++; if (flip_count !== 6'd2) begin errors++; $display("FAIL midrst_rerun_flips: got %0d expected 2", flip_count); end
    checks++; if (wr_q.size() - wb !== 3) begin errors++; $display("FAIL midrst_rerun_nwrites: got %0d expected 3", wr_q.size() - wb); end
  endtask

  initial begin
    test_reset();
    test_up_single();
    test_left_right();
    test_empty_mask();
    test_border();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
